vx_lmem_responder: RTL
======================

# VX_lmem_responder

Responder end of the per-lane data-cache core request/response protocol: accepts the multi-lane request batches that the execute stage's LSU issues, services them from an internal word-addressed local memory, and returns read responses with the originating tag. Sits in the core in place of, or beside, the data-cache front end as a fixed-latency local/scratchpad memory. Stores are absorbed silently and produce no response. Reads return in order through a small response FIFO that provides backpressure to the requester.

## Interface
Parameters:
- NUM_REQS, 4, lanes per batch (≥1)
- TAG_WIDTH, 8, request/response tag width
- SIZE, 1024, memory depth in 32-bit words (power of two)
- RSP_DEPTH, 2, response FIFO entries (power of two, ≥1)

Ports (clock/reset synchronous, active-high, as decided):
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQS  per-lane request valid
- req_rw  in  NUM_REQS  1 = store, 0 = load
- req_byteen  in  NUM_REQS*4  per-lane byte enables (stores only)
- req_addr  in  NUM_REQS*30  per-lane word address
- req_data  in  NUM_REQS*32  per-lane store data
- req_tag  in  NUM_REQS*TAG_WIDTH  per-lane tag
- req_ready  out  NUM_REQS  per-lane ready; all bits always equal
- rsp_valid  out  NUM_REQS  per-lane response valid mask
- rsp_data  out  NUM_REQS*32  per-lane load data
- rsp_tag  out  TAG_WIDTH  batch tag
- rsp_ready  in  1  response consumer ready

## Operation
- Memory index = req_addr[lane][log2(SIZE)-1:0]; upper address bits are ignored (aliasing).
- Batch fires when |req_valid && req_ready[0]; all valid lanes are accepted atomically, with no partial acceptance.
- Loads in a fired batch read memory contents as they were before that batch's stores.
- Stores in a fired batch write the enabled bytes at the clock edge.
- Same-word store conflicts within a batch: the highest-numbered lane wins, resolved per byte.
- Read batch: a fired batch with ≥1 valid load lane pushes one FIFO entry.
  - Entry mask = valid & ~rw.
  - Entry data = per-lane read data; lanes not in the mask hold 0.
  - Entry tag = req_tag of the lowest-numbered valid load lane.
- A store-only batch pushes nothing.
- FIFO head drives rsp_*; rsp_valid = head mask when the FIFO is non-empty, else 0.
- An entry pops when |rsp_valid && rsp_ready.
- req_ready = (count < RSP_DEPTH), registered from count. It does not depend on req_valid or rsp_ready, and it applies to store batches too, which keeps ordering simple.
- Count rules:
  - push with no pop: count+1
  - pop with no push: count-1
  - push and pop together: count unchanged
- Memory contents are not reset.
- Reset clears the FIFO pointers and count. In-flight entries are discarded; stores already written are retained.

## Timing
- Reset values: rsp_valid = 0, rsp_data = 0, rsp_tag = 0, req_ready = all-ones starting the first cycle after reset deasserts. While reset is high, req_ready = 0.
- Load latency: a batch fired at edge N presents its response in cycle N+1 (FIFO was empty) and holds it until popped.
- Throughput: with RSP_DEPTH ≥ 2 and rsp_ready held high, one read batch is accepted per cycle.
- With RSP_DEPTH = 1, the maximum rate is one read batch every 2 cycles.
- Stalled response: rsp_* stay stable while rsp_valid ≠ 0 and rsp_ready = 0.
- FIFO full: req_ready drops in the cycle after the push that fills it. It reasserts in the cycle after the first pop.
- Store-then-load, same word:
  - in consecutive batches, the load sees the new data;
  - within the same batch, the load sees the old data.
- Pointers wrap modulo RSP_DEPTH.

## Test plan
- Store lane0 addr 0x10 data 0xDEADBEEF byteen 0xF, then load lanes 0–3 addrs 0x10,0x11,0x10,0x12 tag 0x5A → one cycle later rsp_valid = 0xF, lane0 = lane2 = 0xDEADBEEF, rsp_tag = 0x5A.
- Byte enables: store 0x11223344 with byteen 0x5 to a zeroed word → load returns 0x00220044.
- Intra-batch conflict: lanes 1 and 3 both store to addr 7 with data 0xA and 0xB → load returns 0xB. A mixed batch containing a lane2 load of addr 7 returns the old value with rsp_valid = 0x4.
- Backpressure, RSP_DEPTH = 2: rsp_ready = 0 with 3 consecutive read batches (tags 1, 2, 3) → req_ready deasserts after the second push. Third batch is held; releasing rsp_ready yields tags 1, 2, 3 in order and no loss.
- Streaming: rsp_ready = 1, 16 back-to-back read batches → 16 responses in consecutive cycles, req_ready never drops.
- Reset with 2 entries queued → the cycle after reset has rsp_valid = 0. Memory written before reset still reads back its written value.

Source files
------------

// File: rtl/vx_lmem_responder.sv
// Purpose: word-addressed local memory answering multi-lane LSU batches; stores are absorbed, reads are queued.
// Latency: a read batch accepted at edge N presents its response in cycle N+1 when the response FIFO was empty.
// Backpressure: req_ready is registered from the FIFO count and drops for all batches while the FIFO is full.
module vx_lmem_responder #(
  parameter int NUM_REQS  = 4,
  parameter int TAG_WIDTH = 8,
  parameter int SIZE      = 1024,
  parameter int RSP_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS-1:0]           req_rw,
  input  logic [NUM_REQS*4-1:0]         req_byteen,
  input  logic [NUM_REQS*30-1:0]        req_addr,
  input  logic [NUM_REQS*32-1:0]        req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [NUM_REQS*32-1:0]        rsp_data,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  input  logic                          rsp_ready
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [31:0]             mem [SIZE];
  logic [AW-1:0]           lane_idx [NUM_REQS];
  logic [NUM_REQS-1:0]     ld_mask;
  logic [NUM_REQS*32-1:0]  rd_data;
  logic [TAG_WIDTH-1:0]    ld_tag;
  logic                    fire;
  logic                    push;
  logic                    pop;

  logic [NUM_REQS-1:0]     fifo_mask [RSP_DEPTH];
  logic [NUM_REQS*32-1:0]  fifo_data [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]    fifo_tag  [RSP_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic                    rdy_q;

  // Upper address bits alias onto the low index bits by design.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_idx
    assign lane_idx[g] = req_addr[g*30 +: AW];
  end

  // ready is forced low while reset is held; otherwise it follows the registered count
  assign req_ready = {NUM_REQS{rdy_q & ~reset}};
  assign fire      = (|req_valid) & rdy_q & ~reset;
  assign push      = fire & (|ld_mask);
  assign pop       = (|rsp_valid) & rsp_ready;

  // Pre-store read of every load lane; tag comes from the lowest-numbered load lane
  always_comb begin
    ld_mask = req_valid & ~req_rw;
    rd_data = '0;
    ld_tag  = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (ld_mask[i]) begin
        rd_data[i*32 +: 32] = mem[lane_idx[i]];
        ld_tag              = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Byte-granular stores; later lanes overwrite earlier ones, so the highest lane wins per byte
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (req_valid[i] && req_rw[i] && req_byteen[i*4 + b]) begin
            mem[lane_idx[i]][b*8 +: 8] <= req_data[i*32 + b*8 +: 8];
          end
        end
      end
    end
  end

  // Occupancy update for simultaneous push/pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO pointers, count and registered ready; reset discards queued entries
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b1;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count_next;
      rdy_q <= (count_next < CW'(RSP_DEPTH));
    end
  end

  // FIFO storage needs no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mask[wr_ptr] <= ld_mask;
      fifo_data[wr_ptr] <= rd_data;
      fifo_tag[wr_ptr]  <= ld_tag;
    end
  end

  // Head of FIFO drives the response; everything reads zero while empty
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_tag   = '0;
    if (count != '0) begin
      rsp_valid = fifo_mask[rd_ptr];
      rsp_data  = fifo_data[rd_ptr];
      rsp_tag   = fifo_tag[rd_ptr];
    end
  end

endmodule
